// File: rtl/nvdla_csb_arbiter.sv
// Two-port AXI-lite to CSB arbiter: round-robin with sequencer lock; one transaction at a time.
// Grant-to-response >= 3 cycles; upstream waits on its ready, downstream stalls hold state.
module nvdla_csb_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    // s0: host control path
    input  logic [ADDR_WIDTH-1:0]   s0_awaddr,
    input  logic                    s0_awvalid,
    output logic                    s0_awready,
    input  logic [DATA_WIDTH-1:0]   s0_wdata,
    input  logic [DATA_WIDTH/8-1:0] s0_wstrb,
    input  logic                    s0_wvalid,
    output logic                    s0_wready,
    output logic [1:0]              s0_bresp,
    output logic                    s0_bvalid,
    input  logic                    s0_bready,
    input  logic [ADDR_WIDTH-1:0]   s0_araddr,
    input  logic                    s0_arvalid,
    output logic                    s0_arready,
    output logic [DATA_WIDTH-1:0]   s0_rdata,
    output logic [1:0]              s0_rresp,
    output logic                    s0_rvalid,
    input  logic                    s0_rready,
    // s1: local config sequencer
    input  logic [ADDR_WIDTH-1:0]   s1_awaddr,
    input  logic                    s1_awvalid,
    output logic                    s1_awready,
    input  logic [DATA_WIDTH-1:0]   s1_wdata,
    input  logic [DATA_WIDTH/8-1:0] s1_wstrb,
    input  logic                    s1_wvalid,
    output logic                    s1_wready,
    output logic [1:0]              s1_bresp,
    output logic                    s1_bvalid,
    input  logic                    s1_bready,
    input  logic [ADDR_WIDTH-1:0]   s1_araddr,
    input  logic                    s1_arvalid,
    output logic                    s1_arready,
    output logic [DATA_WIDTH-1:0]   s1_rdata,
    output logic [1:0]              s1_rresp,
    output logic                    s1_rvalid,
    input  logic                    s1_rready,
    input  logic                    s1_lock,
    // m: toward the CSB
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    input  logic [1:0]              m_bresp,
    input  logic                    m_bvalid,
    output logic                    m_bready,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]              m_rresp,
    input  logic                    m_rvalid,
    output logic                    m_rready,
    output logic                    busy,
    output logic                    grant_id
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [STRB_WIDTH-1:0] strb;
    } req_t;

    typedef enum logic [2:0] {
        IDLE, WR_ISSUE, WR_RESP, WR_RET, RD_ISSUE, RD_RESP, RD_RET
    } state_t;

    state_t                state, state_nxt;
    req_t                  req_q, req_in;
    logic                  aw_pend, w_pend;
    logic [1:0]            resp_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic s0_wr_req, s1_wr_req, s0_ok, s1_ok;
    logic win_vld, win_id, win_wr, grant;

    // s0 is held off only while the sequencer owns the bus and keeps the lock
    assign s0_wr_req = s0_awvalid & s0_wvalid;
    assign s1_wr_req = s1_awvalid & s1_wvalid;
    assign s0_ok     = (s0_wr_req | s0_arvalid) & ~(s1_lock & grant_id);
    assign s1_ok     = s1_wr_req | s1_arvalid;

    always_comb begin
        win_vld = s0_ok | s1_ok;
        win_id  = 1'b0;
        if (s0_ok && s1_ok) begin
            win_id = ~grant_id;
        end else if (s1_ok) begin
            win_id = 1'b1;
        end
    end

    assign win_wr = win_id ? s1_wr_req : s0_wr_req;
    assign grant  = (state == IDLE) & win_vld & ~ap_rst;

    always_comb begin
        req_in.data = win_id ? s1_wdata : s0_wdata;
        req_in.strb = win_id ? s1_wstrb : s0_wstrb;
        if (win_wr) begin
            req_in.addr = win_id ? s1_awaddr : s0_awaddr;
        end else begin
            req_in.addr = win_id ? s1_araddr : s0_araddr;
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            grant_id <= 1'b1;
            req_q    <= '0;
            aw_pend  <= 1'b0;
            w_pend   <= 1'b0;
            resp_q   <= 2'b00;
            rdata_q  <= '0;
        end else begin
            if (grant) begin
                grant_id <= win_id;
                req_q    <= req_in;
                aw_pend  <= win_wr;
                w_pend   <= win_wr;
            end
            if (state == WR_ISSUE) begin
                if (aw_pend && m_awready) aw_pend <= 1'b0;
                if (w_pend && m_wready)   w_pend  <= 1'b0;
            end
            if (state == WR_RESP && m_bvalid) begin
                resp_q <= m_bresp;
            end
            if (state == RD_RESP && m_rvalid) begin
                resp_q  <= m_rresp;
                rdata_q <= m_rdata;
            end
        end
    end

    assign m_awaddr = req_q.addr;
    assign m_araddr = req_q.addr;
    assign m_wdata  = req_q.data;
    assign m_wstrb  = req_q.strb;
    assign busy     = (state != IDLE);

    always_comb begin
        state_nxt  = state;
        s0_awready = 1'b0; s0_wready = 1'b0; s0_arready = 1'b0;
        s1_awready = 1'b0; s1_wready = 1'b0; s1_arready = 1'b0;
        s0_bvalid  = 1'b0; s0_bresp  = 2'b00;
        s1_bvalid  = 1'b0; s1_bresp  = 2'b00;
        s0_rvalid  = 1'b0; s0_rresp  = 2'b00; s0_rdata = '0;
        s1_rvalid  = 1'b0; s1_rresp  = 2'b00; s1_rdata = '0;
        m_awvalid  = 1'b0; m_wvalid  = 1'b0;  m_bready = 1'b0;
        m_arvalid  = 1'b0; m_rready  = 1'b0;
        case (state)
            IDLE: begin
                if (grant) begin
                    if (win_wr) begin
                        state_nxt = WR_ISSUE;
                        if (win_id) begin
                            s1_awready = 1'b1; s1_wready = 1'b1;
                        end else begin
                            s0_awready = 1'b1; s0_wready = 1'b1;
                        end
                    end else begin
                        state_nxt = RD_ISSUE;
                        if (win_id) s1_arready = 1'b1;
                        else        s0_arready = 1'b1;
                    end
                end
            end
            WR_ISSUE: begin
                m_awvalid = aw_pend;
                m_wvalid  = w_pend;
                // both channels may finish in either order, or together
                if ((!aw_pend || m_awready) && (!w_pend || m_wready)) begin
                    state_nxt = WR_RESP;
                end
            end
            WR_RESP: begin
                m_bready = 1'b1;
                if (m_bvalid) state_nxt = WR_RET;
            end
            WR_RET: begin
                if (grant_id) begin
                    s1_bvalid = 1'b1; s1_bresp = resp_q;
                    if (s1_bready) state_nxt = IDLE;
                end else begin
                    s0_bvalid = 1'b1; s0_bresp = resp_q;
                    if (s0_bready) state_nxt = IDLE;
                end
            end
            RD_ISSUE: begin
                m_arvalid = 1'b1;
                if (m_arready) state_nxt = RD_RESP;
            end
            RD_RESP: begin
                m_rready = 1'b1;
                if (m_rvalid) state_nxt = RD_RET;
            end
            RD_RET: begin
                if (grant_id) begin
                    s1_rvalid = 1'b1; s1_rresp = resp_q; s1_rdata = rdata_q;
                    if (s1_rready) state_nxt = IDLE;
                end else begin
                    s0_rvalid = 1'b1; s0_rresp = resp_q; s0_rdata = rdata_q;
                    if (s0_rready) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: doc/nvdla_csb_arbiter.md
NVDLA_CSB_ARBITER -- requirements
Module: nvdla_csb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, CSB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, CSB data width; strobe width is DATA_WIDTH/8.
REQ-003 SHALL have port ap_clk, input, 1, the single clock; all logic rising-edge.
REQ-004 SHALL have port ap_rst, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have, for each upstream AXI-lite slave port s0_ (host control path) and s1_ (local config sequencer):
- awaddr, araddr: input, ADDR_WIDTH.
- wdata: input, DATA_WIDTH.
- wstrb: input, DATA_WIDTH/8.
- awvalid, wvalid, arvalid, bready, rready: input, 1.
- awready, wready, arready, bvalid, rvalid: output, 1.
- bresp, rresp: output, 2.
- rdata: output, DATA_WIDTH.
REQ-006 SHALL have port s1_lock, input, 1; sequencer requests exclusive CSB ownership.
REQ-007 SHALL have a downstream AXI-lite master port m_ toward the NVDLA CSB.
- Signals are the same set as REQ-005 with directions inverted.
REQ-008 SHALL have port busy, output, 1; high whenever the FSM is not in IDLE.
REQ-009 SHALL have port grant_id, output, 1; index of the current or most recent owner.

Function
REQ-010 SHALL run one transaction at a time using FSM states IDLE, WR_ISSUE, WR_RESP, WR_RET, RD_ISSUE, RD_RESP, RD_RET.
REQ-011 SHALL define requests in IDLE as follows.
- Write request of port i: awvalid & wvalid.
- Read request of port i: arvalid.
- Within one port, a write wins over a read.
REQ-012 SHALL arbitrate between ports round-robin: on a simultaneous request the port not equal to grant_id wins.
REQ-013 SHALL not grant s0 while s1_lock=1 and grant_id=1; s1 requests remain grantable during lock.
REQ-014 SHALL, in the grant cycle, capture address/data/strobe into registers and pulse the winner's ready for exactly one cycle.
- Write grant pulses awready and wready; read grant pulses arready.
- grant_id updates in the same cycle.
REQ-015 SHALL, in WR_ISSUE, assert m_awvalid and m_wvalid from the registers starting the cycle after grant.
- Each valid drops independently on its own handshake.
- The FSM moves to WR_RESP once both handshakes have completed, in any order or the same cycle.
REQ-016 SHALL, in WR_RESP, hold m_bready=1; on m_bvalid, capture m_bresp and move to WR_RET.
REQ-017 SHALL, in WR_RET, hold the owner's bvalid=1 with the captured bresp until bready, then return to IDLE.
REQ-018 SHALL handle reads the same way: RD_ISSUE asserts m_arvalid; RD_RESP holds m_rready and captures rdata/rresp; RD_RET returns them on the owner's rvalid/rready.
REQ-019 SHALL keep every non-owner upstream ready/valid output at 0, with data outputs at 0.
REQ-020 SHALL pass responses through unaltered, SLVERR included, and never generate responses itself.
REQ-021 SHALL give a minimum write latency, upstream grant to upstream bvalid, of 3 cycles with zero-wait downstream; reads identical.
REQ-022 SHALL grant in IDLE in the same cycle a request is seen; no idle bubble after RET when a request is pending is not required (one IDLE cycle allowed).
REQ-023 SHALL not let upstream deassertion of valid after grant affect the captured transaction.

Reset
REQ-024 SHALL, while ap_rst=1, force state IDLE, grant_id=1 (so s0 wins the first tie), and busy=0.
REQ-025 SHALL, while ap_rst=1, force all valid/ready outputs to 0 and all data/resp outputs to 0.
REQ-026 SHALL, on reset mid-transaction, abandon the transaction with no response to either upstream port.

Verification
REQ-027 Single write: s0 writes addr 0x0000_5004, data 0xDEAD_BEEF, wstrb 0xF, zero-wait slave -> one m_aw/m_w handshake carrying those values; s0_bvalid with bresp=0 exactly 3 cycles after grant.
REQ-028 Tie: s0 and s1 request writes in the same cycle after reset -> s0 served first, then s1; grant_id sequence 0,1.
REQ-029 Lock: s1_lock=1 with s1 issuing 4 back-to-back writes while s0 reads continuously -> all 4 s1 writes complete before s0_arready; s0 is granted once lock drops.
REQ-030 Split handshake: m_awready delayed 2 cycles, m_wready immediate -> m_wvalid drops after 1 cycle, m_awvalid held 3 cycles; WR_RESP entered only after both.
REQ-031 Read error plus backpressure: slave returns rresp=2'b10, rdata 0x1234_5678; s1_rready low for 5 cycles -> s1_rvalid held stable with those values for 5 cycles.
REQ-032 Reset in WR_RESP: assert ap_rst -> next edge busy=0 and all upstream outputs 0; no bvalid is seen afterwards.
